// File: rtl/uart_reg_sequencer.sv
// Host-side sequencer for a 16550-style UART register block: runs the bring-up writes,
// then services a TX byte stream and an RX byte stream by polling LSR, with round-robin
// arbitration when both sides can proceed.
module uart_reg_sequencer #(
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter logic [7:0]  LCR_CFG  = 8'h03,
  parameter logic [7:0]  FCR_CFG  = 8'h07,
  parameter logic [7:0]  IER_CFG  = 8'h00,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cfg_done,
  output logic       busy,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [3:0] lsr_err,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [2:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  typedef enum logic [3:0] {
    StIdle, StWLcrd, StWDll, StWDlm, StWLcr, StWFcr, StWIer,
    StReady, StPoll, StTxWr, StRxRd, StWait
  } state_e;

  state_e     state_q, state_d;
  logic       rr_q;        // 0: TX wins the next tie, 1: RX wins
  logic [7:0] gap_cnt_q;
  logic       cfg_done_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic [3:0] lsr_err_q;
  logic       tx_grant, rx_grant, start_acc;

  assign start_acc = start && (state_q == StIdle || state_q == StReady);

  // Next-state logic and POLL arbitration.
  always_comb begin
    state_d  = state_q;
    tx_grant = 1'b0;
    rx_grant = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StWLcrd;
      StWLcrd: state_d = StWDll;
      StWDll:  state_d = StWDlm;
      StWDlm:  state_d = StWLcr;
      StWLcr:  state_d = StWFcr;
      StWFcr:  state_d = StWIer;
      StWIer:  state_d = StReady;
      StReady: begin
        if (start)                       state_d = StWLcrd;
        else if (tx_valid || !rx_valid_q) state_d = StPoll;
      end
      StPoll: begin
        // rdata[5] = THRE, rdata[0] = DR
        if ((tx_valid && rdata[5]) && (!rx_valid_q && rdata[0])) begin
          tx_grant = !rr_q;
          rx_grant = rr_q;
        end else begin
          tx_grant = tx_valid && rdata[5];
          rx_grant = !rx_valid_q && rdata[0];
        end
        if (tx_grant)      state_d = StTxWr;
        else if (rx_grant) state_d = StRxRd;
        else               state_d = StWait;
      end
      StTxWr:  state_d = StReady;
      StRxRd:  state_d = StReady;
      StWait:  if (gap_cnt_q <= 8'd1) state_d = StReady;
      default: state_d = StIdle;
    endcase
  end

  // Moore decode of the register bus strobes from the state register.
  always_comb begin
    cs    = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    addr  = 3'd0;
    wdata = 8'h00;
    unique case (state_q)
      StWLcrd: begin cs = 1'b1; wr = 1'b1; addr = 3'd3; wdata = LCR_CFG | 8'h80;   end
      StWDll:  begin cs = 1'b1; wr = 1'b1; addr = 3'd0; wdata = DIVISOR[7:0];      end
      StWDlm:  begin cs = 1'b1; wr = 1'b1; addr = 3'd1; wdata = DIVISOR[15:8];     end
      StWLcr:  begin cs = 1'b1; wr = 1'b1; addr = 3'd3; wdata = LCR_CFG & 8'h7F;   end
      StWFcr:  begin cs = 1'b1; wr = 1'b1; addr = 3'd2; wdata = FCR_CFG;           end
      StWIer:  begin cs = 1'b1; wr = 1'b1; addr = 3'd1; wdata = IER_CFG;           end
      StTxWr:  begin cs = 1'b1; wr = 1'b1; addr = 3'd0; wdata = tx_data;           end
      StPoll:  begin cs = 1'b1; rd = 1'b1; addr = 3'd5;                            end
      StRxRd:  begin cs = 1'b1; rd = 1'b1; addr = 3'd0;                            end
      default: ;
    endcase
  end

  // State register, arbitration pointer and poll-gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (tx_grant)      rr_q <= 1'b1;
      else if (rx_grant) rr_q <= 1'b0;
      if (state_q == StPoll)      gap_cnt_q <= 8'(POLL_GAP);
      else if (state_q == StWait) gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  // Registered status: cfg_done lags the state by one cycle; RX holding register; sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_done_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      lsr_err_q  <= 4'h0;
    end else begin
      cfg_done_q <= (state_q == StReady) || (state_q == StPoll) || (state_q == StTxWr) ||
                    (state_q == StRxRd) || (state_q == StWait);
      if (state_q == StRxRd) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rdata;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (start_acc)              lsr_err_q <= 4'h0;
      else if (state_q == StPoll) lsr_err_q <= lsr_err_q | rdata[4:1];
    end
  end

  assign cfg_done = cfg_done_q;
  assign busy     = (state_q != StIdle) && (state_q != StReady);
  assign tx_ready = (state_q == StTxWr);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign lsr_err  = lsr_err_q;

endmodule

// File: tb/tb_uart_reg_sequencer.sv
// Self-checking bench for uart_reg_sequencer: per-cycle vector table plus directed
// sequences for poll spacing, sticky LSR errors and mid-sequence reset.
module tb_uart_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, tx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       cfg_done, busy, tx_ready, rx_valid;
  logic [7:0] rx_data;
  logic [3:0] lsr_err;
  logic       cs, wr, rd;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;
  logic [7:0] lsr, rbr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_reg_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_done(cfg_done), .busy(busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .lsr_err(lsr_err),
    .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  // Register block model: LSR at 5, RBR at 0.
  always_comb begin
    rdata = 8'h00;
    if (cs && rd && addr == 3'd5) rdata = lsr;
    else if (cs && rd && addr == 3'd0) rdata = rbr;
  end

  typedef struct {
    logic       rst, start, txv;
    logic [7:0] txd, lsr, rbr;
    logic       rxr;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [29:0] ex(input logic c, input logic w, input logic r,
                                     input logic [2:0] a, input logic [7:0] d,
                                     input logic txr, input logic rxv, input logic [7:0] rxd,
                                     input logic cfg, input logic bsy, input logic [3:0] err);
    return {c, w, r, a, d, txr, rxv, rxd, cfg, bsy, err};
  endfunction

  function automatic logic [29:0] outs();
    return {cs, wr, rd, addr, wdata, tx_ready, rx_valid, rx_data, cfg_done, busy, lsr_err};
  endfunction

  task automatic add_vec(input logic r, input logic s, input logic tv, input logic [7:0] td,
                         input logic [7:0] l, input logic [7:0] b, input logic rr,
                         input logic [29:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.txv = tv; v.txd = td; v.lsr = l; v.rbr = b; v.rxr = rr;
    v.exp = e;
    vecs.push_back(v);
  endtask

  logic [2:0] waddr [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
  logic [7:0] wdat  [6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};

  // The six configuration writes straight after a start from reset.
  task automatic add_cfg(input logic [7:0] l, input logic [7:0] b);
    for (int i = 0; i < 6; i++)
      add_vec(0, 0, 0, 8'h00, l, b, 0, ex(1, 1, 0, waddr[i], wdat[i], 0, 0, 8'h00, 0, 1, 0));
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered at a negedge in IDLE/READY; returns at the negedge where the state is READY.
  task automatic do_config();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Returns #1 after the negedge of the next POLL cycle.
  task automatic wait_poll(input string nm);
    logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (cs && rd && addr == 3'd5) found = 1'b1;
      else @(negedge clk);
    end
    check(nm, found, 1);
  endtask

  initial begin
    int npolls, nwr, last;
    logic set_pend;

    rst = 1'b1; start = 0; tx_valid = 0; tx_data = 0; rx_ready = 0; lsr = 8'h60; rbr = 8'h00;

    // T1 + T2: reset, configuration, then one TX transfer.
    add_vec(1, 0, 0, 8'h00, 8'h60, 8'h00, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_vec(0, 1, 0, 8'h00, 8'h60, 8'h00, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_cfg(8'h60, 8'h00);
    add_vec(0, 0, 1, 8'hA5, 8'h60, 8'h00, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_vec(0, 0, 1, 8'hA5, 8'h60, 8'h00, 0, ex(1, 0, 1, 5, 8'h00, 0, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 1, 8'hA5, 8'h60, 8'h00, 0, ex(1, 1, 0, 0, 8'hA5, 1, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 0, 8'hA5, 8'h60, 8'h00, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    // Reset while in POLL, reconfigure, then T4: arbitration and RX back-pressure.
    add_vec(1, 0, 0, 8'h00, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_vec(0, 1, 0, 8'h00, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_cfg(8'h61, 8'h3C);
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 0, 1, 5, 8'h00, 0, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 1, 0, 0, 8'h77, 1, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 0, 1, 5, 8'h00, 0, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 1, 0, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 0, 1, 5, 8'h00, 0, 1, 8'h3C, 1, 1, 0));
    add_vec(0, 0, 1, 8'h77, 8'h61, 8'h3C, 0, ex(1, 1, 0, 0, 8'h77, 1, 1, 8'h3C, 1, 1, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 1, 0, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 1, 0, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h3C, 1, ex(0, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 1, 0, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h3C, 0, ex(0, 0, 0, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h3C, 0, ex(1, 0, 1, 5, 8'h00, 0, 0, 8'h3C, 1, 1, 0));
    add_vec(0, 0, 0, 8'h77, 8'h61, 8'h5E, 0, ex(1, 0, 1, 0, 8'h00, 0, 0, 8'h3C, 1, 1, 0));
    add_vec(0, 0, 0, 8'h77, 8'h60, 8'h5E, 0, ex(0, 0, 0, 0, 8'h00, 0, 1, 8'h5E, 1, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; tx_valid = vecs[i].txv;
      tx_data = vecs[i].txd; lsr = vecs[i].lsr; rbr = vecs[i].rbr; rx_ready = vecs[i].rxr;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // T3: THRE low for three polls, then high; polls spaced 6 cycles, one THR write.
    lsr = 8'h00;
    do_reset();
    do_config();
    tx_valid = 1'b1; tx_data = 8'h5A;
    npolls = 0; nwr = 0; last = 0; set_pend = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (set_pend) begin lsr = 8'h20; set_pend = 1'b0; end
      #1;
      if (cs && rd && addr == 3'd5 && nwr == 0) begin
        if (npolls > 0) check($sformatf("t3_gap%0d", npolls), c - last, 6);
        last = c;
        npolls++;
        if (npolls == 3) set_pend = 1'b1;
      end
      if (cs && wr && addr == 3'd0) begin
        nwr++;
        check("t3_wdata", wdata, 8'h5A);
        check("t3_txready", tx_ready, 1);
        check("t3_polls_before_write", npolls, 4);
        tx_valid = 1'b0;
      end
    end
    check("t3_nwrites", nwr, 1);

    // T5: error bits sticky across clean polls, cleared by start in READY.
    lsr = 8'h60; rbr = 8'h11;
    do_reset();
    do_config();
    wait_poll("t5_poll1_timeout");
    lsr = 8'h0B;
    @(negedge clk);
    lsr = 8'h60;
    #1;
    check("t5_rbr_read", {cs, rd, addr}, {1'b1, 1'b1, 3'd0});
    @(negedge clk);
    #1;
    check("t5_err_set", lsr_err, 4'b0101);
    check("t5_rx", {rx_valid, rx_data}, {1'b1, 8'h11});
    tx_valid = 1'b1; tx_data = 8'hC3;
    wait_poll("t5_poll2_timeout");
    @(negedge clk);
    #1;
    check("t5_thr_write", {cs, wr, addr, wdata, tx_ready}, {1'b1, 1'b1, 3'd0, 8'hC3, 1'b1});
    tx_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t5_err_sticky", lsr_err, 4'b0101);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t5_err_cleared", lsr_err, 4'h0);
    check("t5_rerun", {cs, wr, addr, wdata}, {1'b1, 1'b1, 3'd3, 8'h83});
    check("t5_rx_kept", {rx_valid, rx_data}, {1'b1, 8'h11});

    // T6: asynchronous reset in W_DLM, then a clean full sequence.
    lsr = 8'h60;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t6_in_dlm", {cs, wr, addr, wdata}, {1'b1, 1'b1, 3'd1, 8'h00});
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_reset", outs(), 30'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t6_idle", outs(), 30'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t6_write%0d", i), {cs, wr, rd, addr, wdata},
            {1'b1, 1'b1, 1'b0, waddr[i], wdat[i]});
      @(negedge clk);
    end
    #1;
    check("t6_ready", {cs, busy, cfg_done}, {1'b0, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    check("t6_cfg_done", cfg_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
